work_ram_port: RTL and testbench
================================

WORK_RAM_PORT -- requirements
Module: work_ram_port

Interface
REQ-001 Parameter ADDR_W, default 13: RAM address width, 2^ADDR_W bytes.
REQ-002 Parameter CLEAR_ON_RESET, default 1: 1 = fill the RAM automatically after reset.
REQ-003 Parameter CLEAR_VALUE, default 8'h00: byte written by the fill engine.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  client request present.
REQ-007 req_ready  out  1  request accepted this cycle when req_valid and req_ready are both high.
REQ-008 req_we  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  ADDR_W  byte address.
REQ-010 req_wdata  in  8  write data.
REQ-011 rsp_valid  out  1  read data valid this cycle.
REQ-012 rsp_rdata  out  8  read data; forced to 8'h00 while rsp_valid=0.
REQ-013 clear_start  in  1  one-cycle pulse requesting a RAM fill.
REQ-014 busy  out  1  fill in progress.
REQ-015 ram_ce, ram_oce, ram_reset, ram_wre  out  1 each  RAM-side controls.
REQ-016 ram_ad  out  ADDR_W  RAM address.
REQ-017 ram_din  out  8  RAM write data.
REQ-018 ram_dout  in  8  RAM read data; valid one clk after the address is sampled (bypass read mode).

Function
REQ-019 The block SHALL have two states: CLEAR and IDLE.
REQ-020 The state register and fill counter SHALL be registered; req_ready SHALL equal (state==IDLE) and busy SHALL equal (state==CLEAR).
REQ-021 In IDLE, a handshake SHALL drive the RAM in the same cycle:
  - ram_ce=1, ram_wre=req_we, ram_ad=req_addr, ram_din=req_wdata.
REQ-022 With no handshake in IDLE, ram_ce and ram_wre SHALL be 0; ram_ad and ram_din are don't-care.
REQ-023 An accepted read at cycle N SHALL produce rsp_valid=1 at cycle N+1 with rsp_rdata=ram_dout; writes SHALL produce no response.
REQ-024 Requests SHALL be accepted every cycle back-to-back with no backpressure on responses; each read yields exactly one response, in order.
REQ-025 A read to the address written in the previous cycle SHALL return the newly written byte.
REQ-026 ram_oce SHALL be constant 1 and ram_reset SHALL be constant 0.
REQ-027 In CLEAR, each cycle SHALL write CLEAR_VALUE to address fill_cnt:
  - ram_ce=1, ram_wre=1, ram_ad=fill_cnt, ram_din=CLEAR_VALUE;
  - fill_cnt counts up from 0.
REQ-028 After writing address 2^ADDR_W-1, the next state SHALL be IDLE. A fill takes exactly 2^ADDR_W cycles with no counter wrap.
REQ-029 clear_start in IDLE SHALL enter CLEAR on the next cycle with fill_cnt=0.
REQ-030 A request handshaken in the same cycle as clear_start SHALL complete normally, including its response at N+1.
REQ-031 clear_start while in CLEAR SHALL be ignored; it neither restarts nor extends the fill.
REQ-032 No rsp_valid SHALL be asserted by fill writes; a read accepted at cycle N still responds at N+1 even if CLEAR has begun.

Reset
REQ-033 While reset is high:
  - state SHALL load CLEAR if CLEAR_ON_RESET=1, else IDLE;
  - fill_cnt=0 and rsp_valid=0;
  - RAM is not written (ram_ce=0 while reset is high).
REQ-034 Reset asserted mid-fill or mid-read SHALL discard the pending response and restart the fill from address 0 when CLEAR_ON_RESET=1.
REQ-035 Following reset release, the first fill write SHALL occur in the first cycle after reset goes low.

Verification
REQ-036 Reset with CLEAR_ON_RESET=1, ADDR_W=13 -> busy=1 for exactly 8192 cycles; req_ready=0 throughout; afterwards reads of 0x0000, 0x1000 and 0x1FFF return 8'h00.
REQ-037 Write 0x0123<=8'hA5 at cycle N, read 0x0123 at N+1 -> rsp_valid=1 at N+2 with rsp_rdata=8'hA5; rsp_valid=0 at N+1.
REQ-038 Reads of addresses 0..3 issued on 4 consecutive cycles after writing 8'h10..8'h13 -> 4 consecutive rsp_valid cycles returning 8'h10..8'h13 in order.
REQ-039 clear_start coincident with an accepted read of 0x0005 (holding 8'h77) -> response 8'h77 on the next cycle; busy rises that same next cycle; clear_start pulsed again 100 cycles later -> busy falls exactly 8192 cycles after it rose.
REQ-040 Reset pulsed at fill_cnt=4000 -> the fill restarts at address 0 and busy stays high for 8192 more cycles; no rsp_valid appears.
REQ-041 CLEAR_ON_RESET=0 -> req_ready=1 in the first cycle after reset; a prior write of 8'h3C to 0x0010, then reset, then a read of 0x0010 -> 8'h3C (contents retained).

Source files
------------

// File: rtl/work_ram_port.sv
// Single-client byte port in front of a synchronous work RAM, with a fill engine that writes a fixed byte everywhere.
// Latency: read accepted at cycle N returns data at N+1; writes and fill writes drive the RAM in the accepting cycle.
// Backpressure: req_ready drops for the whole fill (2^ADDR_W cycles); responses are never backpressured.
module work_ram_port #(
   parameter int          ADDR_W         = 13,
   parameter bit          CLEAR_ON_RESET = 1'b1,
   parameter logic [7:0]  CLEAR_VALUE    = 8'h00
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [7:0]        req_wdata,
   output logic              rsp_valid,
   output logic [7:0]        rsp_rdata,
   input  logic              clear_start,
   output logic              busy,
   output logic              ram_ce,
   output logic              ram_oce,
   output logic              ram_reset,
   output logic              ram_wre,
   output logic [ADDR_W-1:0] ram_ad,
   output logic [7:0]        ram_din,
   input  logic [7:0]        ram_dout
);

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   localparam state_t            RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;
   localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] fill_cnt;
   logic [ADDR_W-1:0] fill_cnt_nxt;
   logic              handshake;

   assign req_ready = (state == IDLE);
   assign busy      = (state == CLEAR);
   assign handshake = req_valid & req_ready;

   // Output register on the RAM is unused; the RAM is never reset, so contents survive our reset.
   assign ram_oce   = 1'b1;
   assign ram_reset = 1'b0;

   // Read data is only meaningful in the cycle after a read was accepted; zero it otherwise.
   assign rsp_rdata = rsp_valid ? ram_dout : 8'h00;

   // State, fill counter and response flag; a reset drops any response still in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RESET_STATE;
         fill_cnt  <= '0;
         rsp_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         fill_cnt  <= fill_cnt_nxt;
         rsp_valid <= handshake & ~req_we;
      end
   end

   // Next state: the fill walks every address once and returns to IDLE; clear_start only counts in IDLE.
   always_comb begin
      state_nxt    = state;
      fill_cnt_nxt = fill_cnt;
      case (state)
         CLEAR: begin
            if (fill_cnt == LAST_ADDR) begin
               state_nxt    = IDLE;
               fill_cnt_nxt = '0;
            end else begin
               fill_cnt_nxt = fill_cnt + ADDR_W'(1);
            end
         end
         IDLE: begin
            if (clear_start) begin
               state_nxt    = CLEAR;
               fill_cnt_nxt = '0;
            end
         end
      endcase
   end

   // RAM drive: fill writes own the RAM in CLEAR, client requests in IDLE; nothing is written while reset is high.
   always_comb begin
      ram_ce  = 1'b0;
      ram_wre = 1'b0;
      ram_ad  = req_addr;
      ram_din = req_wdata;
      if (!reset) begin
         if (state == CLEAR) begin
            ram_ce  = 1'b1;
            ram_wre = 1'b1;
            ram_ad  = fill_cnt;
            ram_din = CLEAR_VALUE;
         end else if (handshake) begin
            ram_ce  = 1'b1;
            ram_wre = req_we;
         end
      end
   end

endmodule

// File: tb/tb_work_ram_port.sv
// Bench for work_ram_port: two instances (fill-on-reset and retain-on-reset) each with a behavioural sync RAM.
// Expected read data comes from a flat byte-array model of the RAM contents as the client should see them.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units after it.
module tb_work_ram_port;

   localparam int         AW    = 13;
   localparam int         DEPTH = 1 << AW;
   localparam logic [7:0] CLR   = 8'h00;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------- instance A: CLEAR_ON_RESET=1 ----------------
   logic          reset = 1'b1;
   logic          req_valid = 1'b0, req_we = 1'b0, clear_start = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [7:0]    req_wdata = '0;
   logic          req_ready, rsp_valid, busy, ram_ce, ram_oce, ram_reset, ram_wre;
   logic [7:0]    rsp_rdata, ram_din, ram_dout;
   logic [AW-1:0] ram_ad;

   work_ram_port #(.ADDR_W(AW), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CLR)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .clear_start(clear_start), .busy(busy), .ram_ce(ram_ce), .ram_oce(ram_oce),
      .ram_reset(ram_reset), .ram_wre(ram_wre), .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout));

   // ---------------- instance B: CLEAR_ON_RESET=0 ----------------
   logic          b_reset = 1'b1;
   logic          b_req_valid = 1'b0, b_req_we = 1'b0, b_clear_start = 1'b0;
   logic [AW-1:0] b_req_addr = '0;
   logic [7:0]    b_req_wdata = '0;
   logic          b_req_ready, b_rsp_valid, b_busy, b_ram_ce, b_ram_oce, b_ram_reset, b_ram_wre;
   logic [7:0]    b_rsp_rdata, b_ram_din, b_ram_dout;
   logic [AW-1:0] b_ram_ad;

   work_ram_port #(.ADDR_W(AW), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(CLR)) dut_b (
      .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
      .clear_start(b_clear_start), .busy(b_busy), .ram_ce(b_ram_ce), .ram_oce(b_ram_oce),
      .ram_reset(b_ram_reset), .ram_wre(b_ram_wre), .ram_ad(b_ram_ad), .ram_din(b_ram_din), .ram_dout(b_ram_dout));

   // Synchronous RAMs, bypass read mode: dout follows din on a write, mem[ad] on a read.
   logic [7:0] mem_a [DEPTH];
   logic [7:0] mem_b [DEPTH];
   always @(posedge clk) begin
      if (ram_ce) begin
         if (ram_wre) begin mem_a[ram_ad] <= ram_din; ram_dout <= ram_din; end
         else         ram_dout <= mem_a[ram_ad];
      end
      if (b_ram_ce) begin
         if (b_ram_wre) begin mem_b[b_ram_ad] <= b_ram_din; b_ram_dout <= b_ram_din; end
         else           b_ram_dout <= mem_b[b_ram_ad];
      end
   end

   // Reference contents of instance A as the client should observe them.
   logic [7:0] exp_mem [DEPTH];

   task automatic model_fill();
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = CLR;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic [AW-1:0] a, input logic [7:0] d, input logic cs);
      req_valid = v; req_we = we; req_addr = a; req_wdata = d; clear_start = cs;
      #1;
   endtask

   task automatic test_reset();
      int n, rdybad, adbad;
      logic [AW-1:0] rd_addr [3];
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_cycle(); drive(1'b1, 1'b1, 13'h0042, 8'hEE, 1'b0);
         checks++;
         if (ram_ce !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_quiet: ram_ce=%b rsp_valid=%b rsp_rdata=%h, need 0/0/00", ram_ce, rsp_valid, rsp_rdata);
         end
      end
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      checks++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin
         failures++; $display("FAIL reset_state: busy=%b req_ready=%b, need 1/0", busy, req_ready);
      end
      next_cycle(); reset = 1'b0; drive(1'b0, 1'b0, '0, '0, 1'b0);
      model_fill();
      checks++;
      if (ram_ce !== 1'b1 || ram_wre !== 1'b1 || ram_ad !== '0 || ram_din !== CLR || ram_oce !== 1'b1 || ram_reset !== 1'b0) begin
         failures++;
         $display("FAIL first_fill_write: ce=%b wre=%b ad=%h din=%h oce=%b rst=%b, need 1/1/0000/%h/1/0",
                  ram_ce, ram_wre, ram_ad, ram_din, ram_oce, ram_reset, CLR);
      end
      n = 0; rdybad = 0; adbad = 0;
      while (busy === 1'b1 && n < 9000) begin
         if (req_ready !== 1'b0) rdybad++;
         if (ram_ad !== AW'(n) || ram_ce !== 1'b1) adbad++;
         n++;
         next_cycle(); drive(1'b0, 1'b0, '0, '0, 1'b0);
      end
      checks++;
      if (n != DEPTH) begin failures++; $display("FAIL reset_fill_len: busy cycles=%0d, need %0d", n, DEPTH); end
      checks++;
      if (rdybad != 0 || adbad != 0) begin
         failures++; $display("FAIL reset_fill_seq: ready-high cycles=%0d bad fill addrs=%0d, need 0/0", rdybad, adbad);
      end
      rd_addr[0] = 13'h0000; rd_addr[1] = 13'h1000; rd_addr[2] = 13'h1FFF;
      for (int i = 0; i < 3; i++) begin
         next_cycle(); drive(1'b1, 1'b0, rd_addr[i], 8'h00, 1'b0);
         checks++;
         if (req_ready !== 1'b1 || ram_ce !== 1'b1 || ram_wre !== 1'b0 || ram_ad !== rd_addr[i]) begin
            failures++;
            $display("FAIL read_drive_%0d: ready=%b ce=%b wre=%b ad=%h, need 1/1/0/%h", i, req_ready, ram_ce, ram_wre, ram_ad, rd_addr[i]);
         end
         next_cycle(); drive(1'b0, 1'b0, '0, '0, 1'b0);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== exp_mem[rd_addr[i]]) begin
            failures++;
            $display("FAIL cleared_read_%0d: rsp_valid=%b rdata=%h, need 1/%h", i, rsp_valid, rsp_rdata, exp_mem[rd_addr[i]]);
         end
      end
   endtask

   task automatic test_write_read();
      next_cycle(); drive(1'b1, 1'b1, 13'h0123, 8'hA5, 1'b0);
      exp_mem[13'h0123] = 8'hA5;
      checks++;
      if (ram_ce !== 1'b1 || ram_wre !== 1'b1 || ram_ad !== 13'h0123 || ram_din !== 8'hA5) begin
         failures++;
         $display("FAIL write_drive: ce=%b wre=%b ad=%h din=%h, need 1/1/0123/a5", ram_ce, ram_wre, ram_ad, ram_din);
      end
      next_cycle(); drive(1'b1, 1'b0, 13'h0123, 8'h00, 1'b0);
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL write_no_rsp: rsp_valid=%b, need 0", rsp_valid); end
      next_cycle(); drive(1'b0, 1'b0, '0, '0, 1'b0);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_mem[13'h0123]) begin
         failures++; $display("FAIL raw_read: rsp_valid=%b rdata=%h, need 1/%h", rsp_valid, rsp_rdata, exp_mem[13'h0123]);
      end
      next_cycle(); drive(1'b0, 1'b0, '0, '0, 1'b0);
      checks++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin
         failures++; $display("FAIL rdata_forced: rsp_valid=%b rdata=%h, need 0/00", rsp_valid, rsp_rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      for (int i = 0; i < 4; i++) begin
         d = 8'h10 + 8'(i);
         next_cycle(); drive(1'b1, 1'b1, AW'(i), d, 1'b0);
         exp_mem[i] = d;
      end
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         if (c < 4) drive(1'b1, 1'b0, AW'(c), 8'h00, 1'b0);
         else       drive(1'b0, 1'b0, '0, '0, 1'b0);
         checks++;
         if (c == 0) begin
            if (rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_pre: rsp_valid=%b, need 0", rsp_valid); end
         end else if (rsp_valid !== 1'b1 || rsp_rdata !== exp_mem[c-1]) begin
            failures++; $display("FAIL b2b_rsp_%0d: rsp_valid=%b rdata=%h, need 1/%h", c-1, rsp_valid, rsp_rdata, exp_mem[c-1]);
         end
      end
   endtask

   task automatic test_random();
      logic v, we, pend;
      logic [AW-1:0] a;
      logic [7:0] d, pend_d;
      int bad;
      pend = 1'b0; pend_d = 8'h00; bad = 0;
      for (int i = 0; i <= 400; i++) begin
         v  = (i < 400) && ($urandom_range(0, 3) != 0);
         we = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH-1)) : AW'($urandom_range(0, 31));
         d  = 8'($urandom);
         next_cycle(); drive(v, we, a, d, 1'b0);
         checks++;
         if (rsp_valid !== pend || rsp_rdata !== (pend ? pend_d : 8'h00)) begin
            failures++; bad++;
            if (bad < 10)
               $display("FAIL random_rsp cyc %0d: rsp_valid=%b rdata=%h, need %b/%h", i, rsp_valid, rsp_rdata, pend, pend ? pend_d : 8'h00);
         end
         pend = v & ~we;
         if (v && we) exp_mem[a] = d;
         pend_d = exp_mem[a];
      end
   endtask

   task automatic test_clear_with_read();
      int n, adbad, rspbad;
      next_cycle(); drive(1'b1, 1'b1, 13'h0005, 8'h77, 1'b0);
      exp_mem[5] = 8'h77;
      next_cycle(); drive(1'b1, 1'b0, 13'h0005, 8'h00, 1'b1);
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL clr_hs: req_ready=%b busy=%b, need 1/0", req_ready, busy);
      end
      next_cycle(); drive(1'b0, 1'b0, '0, '0, 1'b0);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_mem[5] || busy !== 1'b1) begin
         failures++;
         $display("FAIL clr_coincident: rsp_valid=%b rdata=%h busy=%b, need 1/%h/1", rsp_valid, rsp_rdata, busy, exp_mem[5]);
      end
      model_fill();
      n = 0; adbad = 0; rspbad = 0;
      while (busy === 1'b1 && n < 9000) begin
         if (ram_ad !== AW'(n) || ram_ce !== 1'b1 || ram_wre !== 1'b1) adbad++;
         if (n > 0 && rsp_valid !== 1'b0) rspbad++;
         n++;
         next_cycle(); drive(1'b0, 1'b0, '0, '0, n == 100);
      end
      checks++;
      if (n != DEPTH) begin failures++; $display("FAIL clr_fill_len: busy cycles=%0d, need %0d", n, DEPTH); end
      checks++;
      if (adbad != 0 || rspbad != 0) begin
         failures++; $display("FAIL clr_fill_seq: bad fill writes=%0d stray rsp=%0d, need 0/0", adbad, rspbad);
      end
      next_cycle(); drive(1'b1, 1'b0, 13'h0005, 8'h00, 1'b0);
      next_cycle(); drive(1'b0, 1'b0, '0, '0, 1'b0);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_mem[5]) begin
         failures++; $display("FAIL clr_overwrote: rsp_valid=%b rdata=%h, need 1/%h", rsp_valid, rsp_rdata, exp_mem[5]);
      end
   endtask

   task automatic test_reset_mid_fill();
      int n, adbad, rspbad;
      next_cycle(); reset = 1'b1; drive(1'b1, 1'b0, 13'h0010, 8'h00, 1'b0);
      checks++;
      if (ram_ce !== 1'b0) begin failures++; $display("FAIL rst_read_ce: ram_ce=%b, need 0", ram_ce); end
      next_cycle(); reset = 1'b0; drive(1'b0, 1'b0, '0, '0, 1'b0);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1 || ram_ad !== '0) begin
         failures++; $display("FAIL rst_read_drop: rsp_valid=%b busy=%b ad=%h, need 0/1/0000", rsp_valid, busy, ram_ad);
      end
      rspbad = 0;
      for (int i = 0; i < 4000; i++) begin
         next_cycle(); drive(1'b0, 1'b0, '0, '0, 1'b0);
         if (rsp_valid !== 1'b0) rspbad++;
      end
      checks++;
      if (ram_ad !== AW'(4000) || busy !== 1'b1) begin
         failures++; $display("FAIL mid_fill_pos: ad=%0d busy=%b, need 4000/1", ram_ad, busy);
      end
      reset = 1'b1; #1;
      checks++;
      if (ram_ce !== 1'b0) begin failures++; $display("FAIL mid_fill_rst_ce: ram_ce=%b, need 0", ram_ce); end
      next_cycle(); reset = 1'b0; drive(1'b0, 1'b0, '0, '0, 1'b0);
      model_fill();
      n = 0; adbad = 0;
      while (busy === 1'b1 && n < 9000) begin
         if (ram_ad !== AW'(n) || ram_ce !== 1'b1) adbad++;
         if (rsp_valid !== 1'b0) rspbad++;
         n++;
         next_cycle(); drive(1'b0, 1'b0, '0, '0, 1'b0);
      end
      checks++;
      if (n != DEPTH || adbad != 0 || rspbad != 0) begin
         failures++;
         $display("FAIL mid_fill_restart: busy cycles=%0d bad addrs=%0d stray rsp=%0d, need %0d/0/0", n, adbad, rspbad, DEPTH);
      end
   endtask

   task automatic test_no_clear_on_reset();
      next_cycle(); b_reset = 1'b0; #1;
      checks++;
      if (b_req_ready !== 1'b1 || b_busy !== 1'b0) begin
         failures++; $display("FAIL noclr_ready: req_ready=%b busy=%b, need 1/0", b_req_ready, b_busy);
      end
      next_cycle();
      b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 13'h0010; b_req_wdata = 8'h3C; #1;
      checks++;
      if (b_ram_ce !== 1'b1 || b_ram_wre !== 1'b1) begin
         failures++; $display("FAIL noclr_write: ce=%b wre=%b, need 1/1", b_ram_ce, b_ram_wre);
      end
      for (int i = 0; i < 2; i++) begin
         next_cycle(); b_reset = 1'b1; b_req_wdata = 8'hFF; #1;
         checks++;
         if (b_ram_ce !== 1'b0) begin failures++; $display("FAIL noclr_rst_ce: ram_ce=%b, need 0", b_ram_ce); end
      end
      next_cycle(); b_reset = 1'b0; b_req_valid = 1'b1; b_req_we = 1'b0; #1;
      checks++;
      if (b_req_ready !== 1'b1 || b_busy !== 1'b0) begin
         failures++; $display("FAIL noclr_ready2: req_ready=%b busy=%b, need 1/0", b_req_ready, b_busy);
      end
      next_cycle(); b_req_valid = 1'b0; #1;
      checks++;
      if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 8'h3C) begin
         failures++; $display("FAIL noclr_retain: rsp_valid=%b rdata=%h, need 1/3c", b_rsp_valid, b_rsp_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_random();
      test_clear_with_read();
      test_reset_mid_fill();
      test_no_clear_on_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
